conv2d_opt_mem_if: RTL

- Memory-side partner of the optimized conv2D compute datapath.
- On start, reads WT_DIM x WT_DIM weights, then fm_dim x fm_dim IFM words, from DMem and streams them in order to the compute engine over a valid/ready stream.
- Concurrently accepts OFM words from the compute engine and writes them to DMem.
- Sits between the accelerator's DMem port and the compute block. Reads and writes share one request channel.

---
 rtl/conv2d_opt_mem_if.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/conv2d_opt_mem_if.sv
// rtl/conv2d_opt_mem_if.sv - DMem-side read streamer and OFM writer for the conv2D compute engine
module conv2d_opt_mem_if #(
  parameter int AWIDTH   = 32,
  parameter int DWIDTH   = 32,
  parameter int WT_DIM   = 3,
  parameter int LOGDEPTH = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              idle,
  output logic              done,
  input  logic [31:0]       fm_dim,
  input  logic [AWIDTH-1:0] wt_base,
  input  logic [AWIDTH-1:0] ifm_base,
  input  logic [AWIDTH-1:0] ofm_base,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_write,
  output logic [AWIDTH-1:0] mem_req_addr,
  output logic [DWIDTH-1:0] mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [DWIDTH-1:0] mem_resp_data,
  output logic [DWIDTH-1:0] rdata,
  output logic              rdata_valid,
  input  logic              rdata_ready,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              wdata_valid,
  output logic              wdata_ready
);

  localparam int                DEPTH   = 1 << LOGDEPTH;
  localparam logic [31:0]       WT_SQ   = 32'(WT_DIM * WT_DIM);
  localparam logic [LOGDEPTH:0] DEPTH_C = (LOGDEPTH+1)'(DEPTH);
  localparam logic [LOGDEPTH:0] ONE_C   = (LOGDEPTH+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [AWIDTH-1:0]   wt_base_q, ifm_base_q, ofm_base_q;
  logic [31:0]         rd_total, wr_total, rd_issued, wr_issued, wr_accepted;
  logic [LOGDEPTH:0]   outstanding, fifo_count;
  logic [LOGDEPTH-1:0] wr_ptr, rd_ptr;
  logic [DWIDTH-1:0]   fifo_mem [DEPTH];
  logic                hold_valid;
  logic [DWIDTH-1:0]   hold_data;
  logic                rd_locked;

  logic                run, rd_can, sel_write, job_complete;
  logic                req_fire, rd_fire, wr_fire, wd_fire;
  logic                resp_en, resp_dec, enq, deq;
  logic [31:0]         ifm_idx;
  logic [AWIDTH-1:0]   rd_addr, wr_addr;
  logic [LOGDEPTH+1:0] occupancy;

  assign run       = (state_q == S_RUN);
  assign ifm_idx   = rd_issued - WT_SQ;
  assign rd_addr   = (rd_issued < WT_SQ) ? wt_base_q + AWIDTH'({rd_issued, 2'b00})
                                         : ifm_base_q + AWIDTH'({ifm_idx, 2'b00});
  assign wr_addr   = ofm_base_q + AWIDTH'({wr_issued, 2'b00});
  assign occupancy = {1'b0, outstanding} + {1'b0, fifo_count};
  // Reads stop once in-flight plus buffered words could fill the buffer, so it never overflows.
  assign rd_can    = run && (rd_issued < rd_total) && (occupancy < (LOGDEPTH+2)'(DEPTH));
  // A read already stalled on the channel keeps it, so request fields never change mid-stall.
  assign sel_write = hold_valid && !rd_locked;

  assign req_fire  = mem_req_valid && mem_req_ready;
  assign rd_fire   = req_fire && !mem_req_write;
  assign wr_fire   = req_fire && mem_req_write;
  assign wd_fire   = wdata_valid && wdata_ready;
  assign resp_en   = run && mem_resp_valid;
  assign resp_dec  = resp_en && (outstanding != '0);
  assign deq       = rdata_valid && rdata_ready;
  assign enq       = resp_en && ((fifo_count != DEPTH_C) || deq);
  assign rdata       = fifo_mem[rd_ptr];
  assign rdata_valid = (fifo_count != '0);

  assign job_complete = (rd_issued == rd_total) && (outstanding == '0) &&
                        (fifo_count == '0) && (wr_issued == wr_total);

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (job_complete) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    idle          = (state_q == S_IDLE);
    done          = (state_q == S_DONE);
    mem_req_valid = run && (hold_valid || rd_can);
    mem_req_write = sel_write;
    mem_req_addr  = sel_write ? wr_addr : rd_addr;
    mem_req_wdata = hold_data;
    // The holding slot may be refilled in the same cycle its write is accepted.
    wdata_ready   = run && (wr_accepted < wr_total) && (!hold_valid || wr_fire);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wt_base_q   <= '0;
      ifm_base_q  <= '0;
      ofm_base_q  <= '0;
      rd_total    <= '0;
      wr_total    <= '0;
      rd_issued   <= '0;
      wr_issued   <= '0;
      wr_accepted <= '0;
      outstanding <= '0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      hold_valid  <= 1'b0;
      hold_data   <= '0;
      rd_locked   <= 1'b0;
    end else if (idle && start) begin
      wt_base_q   <= wt_base;
      ifm_base_q  <= ifm_base;
      ofm_base_q  <= ofm_base;
      rd_total    <= WT_SQ + fm_dim * fm_dim;
      wr_total    <= fm_dim * fm_dim;
      rd_issued   <= '0;
      wr_issued   <= '0;
      wr_accepted <= '0;
      outstanding <= '0;
      hold_valid  <= 1'b0;
      rd_locked   <= 1'b0;
    end else begin
      if (rd_fire) rd_issued   <= rd_issued + 32'd1;
      if (wr_fire) wr_issued   <= wr_issued + 32'd1;
      if (wd_fire) wr_accepted <= wr_accepted + 32'd1;
      if (rd_fire && !resp_dec)      outstanding <= outstanding + ONE_C;
      else if (!rd_fire && resp_dec) outstanding <= outstanding - ONE_C;
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      if (enq && !deq)      fifo_count <= fifo_count + ONE_C;
      else if (!enq && deq) fifo_count <= fifo_count - ONE_C;
      if (wd_fire) begin
        hold_valid <= 1'b1;
        hold_data  <= wdata;
      end else if (wr_fire) begin
        hold_valid <= 1'b0;
      end
      rd_locked <= mem_req_valid && !mem_req_ready && !mem_req_write;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) fifo_mem[wr_ptr] <= mem_resp_data;
  end

endmodule
